// File: rtl/mc_ram_pkg.sv
// Shared definitions for the MC14500B clocked scratch/flag RAM.
//   ram_state_e : clear-sweep controller states
//   MAX_WORD    : widest data word parity_f accepts
//   parity_f    : even parity (XOR-reduce) of a zero-extended data word
package mc_ram_pkg;

    typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_e;

    localparam int MAX_WORD = 64;

    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic parity_f(input logic [MAX_WORD-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mc_ram_clear_ctrl.sv
// Zero-fill sweep controller for mc_ram_sync.
// After reset, this block walks every address once, writing zero to each. It then parks in IDLE.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset; the sweep restarts from address 0
//   busy     out  high while the sweep is in progress
//   clr_we   out  write strobe for the sweep write
//   clr_addr out  address the sweep writes this cycle
module mc_ram_clear_ctrl
    import mc_ram_pkg::*;
#(
    parameter int SIZE_LOG = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                busy,
    output logic                clr_we,
    output logic [SIZE_LOG-1:0] clr_addr
);

    ram_state_e          state_q, state_d;
    logic [SIZE_LOG-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAM_CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            RAM_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                addr_d = addr_q + 1'b1;
                // The write to the last address ends the sweep.
                if (&addr_q) begin
                    state_d = RAM_IDLE;
                end
            end
            RAM_IDLE: ;
            default: state_d = RAM_CLEAR;
        endcase
    end

    assign clr_addr = addr_q;

endmodule

// File: rtl/mc_ram_sync.sv
// Single-clock simple-dual-port scratch/flag RAM for the MC14500B system.
// Reads are registered with a 1-cycle latency. The array is zero-filled after every reset.
// Optional feature macro: RAM_PARITY_EN adds one stored parity bit per word,
// the par_inject input and the parity_err output.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   we, waddr, wdata  write port (ignored while busy)
//   re, raddr         read request (ignored while busy)
//   rdata, rvalid     registered read data; rvalid pulses for one cycle for each accepted read
//   busy              clear sweep in progress
//   par_inject        (RAM_PARITY_EN) invert the stored parity of this write
//   parity_err        (RAM_PARITY_EN) parity mismatch on the delivered read
module mc_ram_sync
    import mc_ram_pkg::*;
#(
    parameter int WORD        = 1,
    parameter int SIZE_LOG    = 8,
    parameter int WRITE_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [SIZE_LOG-1:0] waddr,
    input  logic [WORD-1:0]     wdata,
    input  logic                re,
    input  logic [SIZE_LOG-1:0] raddr,
    output logic [WORD-1:0]     rdata,
    output logic                rvalid,
    output logic                busy
`ifdef RAM_PARITY_EN
    ,
    input  logic                par_inject,
    output logic                parity_err
`endif
);

    localparam int SIZE = 2 ** SIZE_LOG;
    localparam bit WF   = (WRITE_FIRST != 0);

    logic                clr_we;
    logic [SIZE_LOG-1:0] clr_addr;

    mc_ram_clear_ctrl #(
        .SIZE_LOG (SIZE_LOG)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [WORD-1:0] mem [SIZE];

    // The sweep owns the write port while busy.
    logic                w_en;
    logic [SIZE_LOG-1:0] w_addr;
    logic [WORD-1:0]     w_data;
    logic                rd_en;
    logic                bypass;
    logic [WORD-1:0]     rd_word;

    always_comb begin
        w_en    = busy ? clr_we : we;
        w_addr  = busy ? clr_addr : waddr;
        w_data  = busy ? '0 : wdata;
        rd_en   = re && !busy;
        bypass  = WF && we && (waddr == raddr);
        rd_word = bypass ? wdata : mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_word;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic mem_par [SIZE];
    logic user_par;
    logic w_par;
    logic rd_par;

    always_comb begin
        user_par = parity_f(MAX_WORD'(wdata)) ^ par_inject;
        w_par    = busy ? 1'b0 : user_par;
        rd_par   = bypass ? user_par : mem_par[raddr];
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_par[w_addr] <= w_par;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_en && (parity_f(MAX_WORD'(rd_word)) != rd_par);
        end
    end
`endif

endmodule

// File: tb/tb_mc_ram_sync.sv
// Testbench for mc_ram_sync with WORD=4 and SIZE_LOG=4.
// Two instances share one stimulus stream: one is write-first and one is read-first.
// A word-array model predicts rdata, rvalid and busy for each instance.
module tb_mc_ram_sync;

    logic       clk = 1'b0;
    logic       rst, we, re;
    logic [3:0] waddr, wdata, raddr;
    logic [3:0] rdata1, rdata0;
    logic       rvalid1, rvalid0, busy1, busy0;
`ifdef RAM_PARITY_EN
    logic       pinj;
    logic       perr1, perr0;
`endif

    always #5 clk = ~clk;

    mc_ram_sync #(.WORD(4), .SIZE_LOG(4), .WRITE_FIRST(1)) dut_wf1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
`ifdef RAM_PARITY_EN
        , .par_inject(pinj), .parity_err(perr1)
`endif
    );

    mc_ram_sync #(.WORD(4), .SIZE_LOG(4), .WRITE_FIRST(0)) dut_wf0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
`ifdef RAM_PARITY_EN
        , .par_inject(pinj), .parity_err(perr0)
`endif
    );

    // Reference model
    logic [3:0] mem_m [16];
    logic       par_m [16];
    int         sweep_left = 16;
    logic       exp_rv;
    logic [3:0] exp_rd1, exp_rd0;
    logic       exp_pe1, exp_pe0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, apply the edge to the model, then compare just after the edge.
    task automatic cyc(input logic r, input logic w, input logic [3:0] wa, input logic [3:0] wd,
                       input logic rd, input logic [3:0] ra);
        rst = r; we = w; waddr = wa; wdata = wd; re = rd; raddr = ra;
        @(posedge clk);
        if (r) begin
            sweep_left = 16;
            exp_rv = 0; exp_rd1 = 0; exp_rd0 = 0; exp_pe1 = 0; exp_pe0 = 0;
            for (int i = 0; i < 16; i++) begin
                mem_m[i] = 4'h0;
                par_m[i] = 1'b0;
            end
        end else if (sweep_left > 0) begin
            sweep_left--;
            exp_rv = 0; exp_pe1 = 0; exp_pe0 = 0;
        end else begin
            exp_rv = rd;
            exp_pe1 = 0; exp_pe0 = 0;
            if (rd) begin
                exp_rd0 = mem_m[ra];
                exp_rd1 = (w && wa == ra) ? wd : mem_m[ra];
`ifdef RAM_PARITY_EN
                exp_pe0 = (^mem_m[ra]) != par_m[ra];
                exp_pe1 = (w && wa == ra) ? pinj : exp_pe0;
`endif
            end
            if (w) begin
                mem_m[wa] = wd;
`ifdef RAM_PARITY_EN
                par_m[wa] = (^wd) ^ pinj;
`endif
            end
        end
        #1;
        chk("busy_wf1", {7'b0, busy1}, {7'b0, sweep_left > 0});
        chk("busy_wf0", {7'b0, busy0}, {7'b0, sweep_left > 0});
        chk("rvalid_wf1", {7'b0, rvalid1}, {7'b0, exp_rv});
        chk("rvalid_wf0", {7'b0, rvalid0}, {7'b0, exp_rv});
        chk("rdata_wf1", {4'b0, rdata1}, {4'b0, exp_rd1});
        chk("rdata_wf0", {4'b0, rdata0}, {4'b0, exp_rd0});
`ifdef RAM_PARITY_EN
        chk("perr_wf1", {7'b0, perr1}, {7'b0, exp_pe1});
        chk("perr_wf0", {7'b0, perr0}, {7'b0, exp_pe0});
`endif
    endtask

    initial begin
        int n;
        rst = 1; we = 0; re = 0; waddr = 0; wdata = 0; raddr = 0;
`ifdef RAM_PARITY_EN
        pinj = 0;
`endif
        // Sweep length, with we/re attempted at address 2 mid-sweep
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        n = 0;
        while (busy1 && n < 40) begin
            if (n == 3) cyc(0, 1, 4'd2, 4'hF, 1, 4'd2);
            else        cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk("sweep_len", n[7:0], 8'd16);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, i[3:0]);
        chk("gated_addr2", {4'b0, rdata1}, 8'h00);

        // Latency and hold
        cyc(0, 1, 4'd5, 4'hA, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd5);
        chk("lat_rdata", {4'b0, rdata1}, 8'h0A);
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_rdata", {4'b0, rdata0}, 8'h0A);

        // Collision
        cyc(0, 1, 4'd3, 4'h1, 0, 0);
        cyc(0, 1, 4'd3, 4'h6, 1, 4'd3);
        chk("coll_wf1", {4'b0, rdata1}, 8'h06);
        chk("coll_wf0", {4'b0, rdata0}, 8'h01);
        cyc(0, 0, 0, 0, 1, 4'd3);
        chk("coll_after_wf0", {4'b0, rdata0}, 8'h06);

        // Reset during the sweep
        cyc(1, 0, 0, 0, 0, 0);
        repeat (7) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        n = 0;
        while (busy0 && n < 40) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk("resweep_len", n[7:0], 8'd16);

`ifdef RAM_PARITY_EN
        pinj = 1;
        cyc(0, 1, 4'd9, 4'h3, 0, 0);
        pinj = 0;
        cyc(0, 0, 0, 0, 1, 4'd9);
        chk("par_inj", {7'b0, perr0}, 8'h01);
        cyc(0, 1, 4'd9, 4'h3, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd9);
        chk("par_clean", {7'b0, perr0}, 8'h00);
`endif

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
`ifdef RAM_PARITY_EN
            pinj = ($urandom_range(0, 7) == 0);
`endif
            cyc($urandom_range(0, 199) == 0, 1'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
